// File: rtl/alu_pkg.sv
// Shared types for the registered ALU: opcode set, flag bit positions and
// the sequencing state of the top level.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_ADC  = 4'd2,
    OP_SBC  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_NOT  = 4'd6,
    OP_XNOR = 4'd7,
    OP_ASR  = 4'd8,
    OP_LSL  = 4'd9,
    OP_LSR  = 4'd10,
    OP_ROL  = 4'd11,
    OP_ROR  = 4'd12,
    OP_RRC  = 4'd13,
    OP_MUL  = 4'd14,
    OP_DIVU = 4'd15
  } alu_op_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
// One-bit-per-cycle unsigned multiply (shift-add) and restoring divide.
// lo/hi/fin present the outcome of the step taken on the current edge.
module alu_muldiv_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             fin,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             dz
);

  localparam int CW = $clog2(WIDTH);

  logic             busy_q;
  logic             div_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   shl;
  logic [WIDTH:0]   add;

  always_comb begin
    // NOTE: every comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    lo_d = lo_q;
    hi_d = hi_q;
    shl  = '0;
    add  = '0;
    if (div_q) begin
      shl = {hi_q, lo_q[WIDTH-1]};
      if (shl >= {1'b0, b_q}) begin
        hi_d = shl[WIDTH-1:0] - b_q;
        lo_d = {lo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi_d = shl[WIDTH-1:0];
        lo_d = {lo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      add          = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      {hi_d, lo_d} = {add, lo_q[WIDTH-1:1]};
    end
  end

  // NOTE: state registers use <= so every flop samples pre-edge values; blocking = stays in comb logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the datapath registers are reset too so dz/lo/hi never expose X after reset.
      busy_q <= 1'b0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
      lo_q   <= '0;
      hi_q   <= '0;
      b_q    <= '0;
    end else if (go && !busy_q) begin
      busy_q <= 1'b1;
      div_q  <= is_div;
      cnt_q  <= CW'(WIDTH - 1);
      lo_q   <= a;
      hi_q   <= '0;
      b_q    <= b;
    end else if (busy_q) begin
      lo_q  <= lo_d;
      hi_q  <= hi_d;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == '0) busy_q <= 1'b0;
    end
  end

  assign busy = busy_q;
  assign fin  = busy_q && (cnt_q == '0);
  assign lo   = lo_d;
  assign hi   = hi_d;
  assign dz   = div_q && (b_q == '0);

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU: 14 single-cycle ops plus iterative MUL/DIVU,
// with a start/done handshake and output registers held between results.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  alu_op_t          alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_hi,
  output logic [3:0]       flags,
  output logic             div0
);

  localparam int M = WIDTH - 1;

  state_t           state_q, state_d;
  logic             is_iter, go, wr;
  logic             it_busy, it_fin, it_dz;
  logic [WIDTH-1:0] it_lo, it_hi;
  logic [WIDTH:0]   ext, cinx;
  logic [WIDTH-1:0] res_y;
  logic             res_c, res_v;
  logic [WIDTH-1:0] y_q, y_d, y_hi_q, y_hi_d;
  logic [3:0]       flags_q, flags_d;
  logic             div0_q, div0_d, done_q;

  assign is_iter = (alu_op == OP_MUL) || (alu_op == OP_DIVU);
  assign go      = start && (state_q == ST_IDLE) && is_iter;
  assign wr      = (start && (state_q == ST_IDLE) && !is_iter) ||
                   ((state_q == ST_RUN) && it_fin);
  assign cinx    = {{WIDTH{1'b0}}, c_in};

  alu_muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst    (rst),
    .go     (go),
    .is_div (alu_op == OP_DIVU),
    .a      (a),
    .b      (b),
    .busy   (it_busy),
    .fin    (it_fin),
    .lo     (it_lo),
    .hi     (it_hi),
    .dz     (it_dz)
  );

  always_comb begin
    ext   = '0;
    res_y = '0;
    res_c = 1'b0;
    res_v = 1'b0;
    case (alu_op)
      OP_ADD, OP_ADC: begin
        ext   = {1'b0, a} + {1'b0, b} + ((alu_op == OP_ADC) ? cinx : '0);
        res_y = ext[M:0];
        res_c = ext[WIDTH];
        res_v = (a[M] == b[M]) && (res_y[M] != a[M]);
      end
      OP_SUB, OP_SBC: begin
        // The WIDTH+1-bit difference goes negative exactly when a < b (+c_in).
        ext   = {1'b0, a} - {1'b0, b} - ((alu_op == OP_SBC) ? cinx : '0);
        res_y = ext[M:0];
        res_c = ext[WIDTH];
        res_v = (a[M] != b[M]) && (res_y[M] != a[M]);
      end
      OP_AND:  res_y = a & b;
      OP_OR:   res_y = a | b;
      OP_NOT:  res_y = ~a;
      OP_XNOR: res_y = ~(a ^ b);
      OP_ASR:  res_y = {a[M], a[M:1]};
      OP_LSL:  res_y = {a[M-1:0], 1'b0};
      OP_LSR:  res_y = {1'b0, a[M:1]};
      OP_ROL:  res_y = {a[M-1:0], a[M]};
      OP_ROR:  res_y = {a[0], a[M:1]};
      OP_RRC: begin
        res_y = {c_in, a[M:1]};
        res_c = a[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (go) state_d = ST_RUN;
      // Also drop back if the iterator is ever found idle, so RUN cannot stick.
      ST_RUN:  if (it_fin || !it_busy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    y_d     = y_q;
    y_hi_d  = y_hi_q;
    flags_d = flags_q;
    div0_d  = div0_q;
    if (wr) begin
      if (state_q == ST_RUN) begin
        y_d             = it_lo;
        y_hi_d          = it_hi;
        div0_d          = it_dz;
        flags_d[FLAG_C] = 1'b0;
        flags_d[FLAG_V] = 1'b0;
      end else begin
        y_d             = res_y;
        y_hi_d          = '0;
        div0_d          = 1'b0;
        flags_d[FLAG_C] = res_c;
        flags_d[FLAG_V] = res_v;
      end
      flags_d[FLAG_Z] = (y_d == '0);
      flags_d[FLAG_N] = y_d[M];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      y_q     <= '0;
      y_hi_q  <= '0;
      flags_q <= '0;
      div0_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      y_hi_q  <= y_hi_d;
      flags_q <= flags_d;
      div0_q  <= div0_d;
      done_q  <= wr;
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign done  = done_q;
  assign y     = y_q;
  assign y_hi  = y_hi_q;
  assign flags = flags_q;
  assign div0  = div0_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=8 and WIDTH=16 against an
// arithmetic reference model of the operation set.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic        s8, c8, busy8, done8, dz8;
  alu_op_t     op8;
  logic [7:0]  a8, b8, y8, yh8;
  logic [3:0]  f8;

  logic        s16, c16, busy16, done16, dz16;
  alu_op_t     op16;
  logic [15:0] a16, b16, y16, yh16;
  logic [3:0]  f16;

  int n_checks = 0;
  int n_errors = 0;

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(s8), .alu_op(op8), .a(a8), .b(b8), .c_in(c8),
    .busy(busy8), .done(done8), .y(y8), .y_hi(yh8), .flags(f8), .div0(dz8)
  );

  alu_seq #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .start(s16), .alu_op(op16), .a(a16), .b(b16), .c_in(c16),
    .busy(busy16), .done(done16), .y(y16), .y_hi(yh16), .flags(f16), .div0(dz16)
  );

  // Result word layout: {y[15:0], y_hi[15:0], flags{V,C,N,Z}, div0}
  function automatic logic [36:0] pack(longint y, longint yhi, logic [3:0] f, logic d);
    logic [15:0] yl, hl;
    yl = y[15:0];
    hl = yhi[15:0];
    return {yl, hl, f, d};
  endfunction

  function automatic logic [36:0] model(int w, int op, longint a, longint b, logic cin);
    longint mask, msb, sa, sb, sr, y, yhi, cl;
    logic   c, v, d;
    mask = (longint'(1) << w) - 1;
    msb  = longint'(1) << (w - 1);
    sa   = (a >= msb) ? a - (mask + 1) : a;
    sb   = (b >= msb) ? b - (mask + 1) : b;
    cl   = cin ? 1 : 0;
    y = 0; yhi = 0; sr = 0; c = 1'b0; v = 1'b0; d = 1'b0;
    case (op)
      0:  begin y = a + b;      c = (y > mask);     sr = sa + sb;      end
      1:  begin y = a - b;      c = (a < b);        sr = sa - sb;      end
      2:  begin y = a + b + cl; c = (y > mask);     sr = sa + sb + cl; end
      3:  begin y = a - b - cl; c = (a < b + cl);   sr = sa - sb - cl; end
      4:  y = a & b;
      5:  y = a | b;
      6:  y = ~a;
      7:  y = ~(a ^ b);
      8:  y = sa >>> 1;
      9:  y = a * 2;
      10: y = a / 2;
      11: y = a * 2 + a / msb;
      12: y = a / 2 + (a % 2) * msb;
      13: begin y = a / 2 + cl * msb; c = (a % 2 == 1); end
      14: begin y = a * b; yhi = (a * b) / (mask + 1); end
      default: begin
        if (b == 0) begin y = mask; yhi = a; d = 1'b1; end
        else begin y = a / b; yhi = a % b; end
      end
    endcase
    if (op < 4) v = (sr > msb - 1) || (sr < -msb);
    y = y & mask;
    return pack(y, yhi, {v, c, (y >= msb), (y == 0)}, d);
  endfunction

  function automatic logic [36:0] observed(int w);
    if (w == 8) return pack(longint'(y8), longint'(yh8), f8, dz8);
    return pack(longint'(y16), longint'(yh16), f16, dz16);
  endfunction

  function automatic logic [1:0] bd(int w);
    if (w == 8) return {busy8, done8};
    return {busy16, done16};
  endfunction

  function automatic longint rnd(int w);
    longint mask;
    mask = (longint'(1) << w) - 1;
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return mask;
      2:       return longint'(1) << (w - 1);
      3:       return (longint'(1) << (w - 1)) - 1;
      default: return longint'($urandom) & mask;
    endcase
  endfunction

  task automatic drive(int w, logic st, int op, longint a, longint b, logic cin);
    if (w == 8) begin
      s8 = st; op8 = alu_op_t'(op[3:0]); a8 = a[7:0]; b8 = b[7:0]; c8 = cin;
    end else begin
      s16 = st; op16 = alu_op_t'(op[3:0]); a16 = a[15:0]; b16 = b[15:0]; c16 = cin;
    end
  endtask

  task automatic scramble(int w);
    drive(w, 1'b0, $urandom_range(0, 15), longint'($urandom), longint'($urandom), 1'($urandom));
  endtask

  task automatic single(string name, int w, int op, longint a, longint b, logic cin,
                        logic [36:0] exp);
    @(negedge clk);
    drive(w, 1'b1, op, a, b, cin);
    @(posedge clk); #1;
    scramble(w);
    n_checks++;
    if (bd(w) !== 2'b01) begin
      n_errors++;
      $display("FAIL %s busy/done got=%b exp=01", name, bd(w));
    end
    n_checks++;
    if (observed(w) !== exp) begin
      n_errors++;
      $display("FAIL %s result got=%h exp=%h", name, observed(w), exp);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bd(w) !== 2'b00 || observed(w) !== exp) begin
      n_errors++;
      $display("FAIL %s hold got=%b/%h exp=00/%h", name, bd(w), observed(w), exp);
    end
  endtask

  task automatic multi(string name, int w, int op, longint a, longint b, logic cin,
                       logic [36:0] exp, int inject);
    int lat;
    bit busy_ok;
    @(negedge clk);
    drive(w, 1'b1, op, a, b, cin);
    @(posedge clk); #1;
    scramble(w);
    n_checks++;
    if (bd(w) !== 2'b10) begin
      n_errors++;
      $display("FAIL %s first busy/done got=%b exp=10", name, bd(w));
    end
    lat = 0;
    busy_ok = 1'b1;
    for (int k = 1; k <= 4 * w; k++) begin
      @(posedge clk); #1;
      if (bd(w)[0] === 1'b1) begin
        lat = k;
        break;
      end
      if (bd(w)[1] !== 1'b1) busy_ok = 1'b0;
      if (k == inject) drive(w, 1'b1, 0, rnd(w), rnd(w), 1'b0);
      if (k == inject + 1) scramble(w);
    end
    scramble(w);
    n_checks++;
    if (lat != w) begin
      n_errors++;
      $display("FAIL %s latency got=%0d exp=%0d (0 = no done)", name, lat, w);
    end
    n_checks++;
    if (!busy_ok || bd(w) !== 2'b01) begin
      n_errors++;
      $display("FAIL %s busy profile busy_ok=%0d busy/done=%b exp 1/01", name, busy_ok, bd(w));
    end
    n_checks++;
    if (observed(w) !== exp) begin
      n_errors++;
      $display("FAIL %s result got=%h exp=%h", name, observed(w), exp);
    end
    @(posedge clk); #1;
    n_checks++;
    if (bd(w) !== 2'b00 || observed(w) !== exp) begin
      n_errors++;
      $display("FAIL %s hold got=%b/%h exp=00/%h", name, bd(w), observed(w), exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int w = 8; w <= 16; w += 8) begin
      n_checks++;
      if (bd(w) !== 2'b00 || observed(w) !== 37'd0) begin
        n_errors++;
        $display("FAIL reset_w%0d got=%b/%h exp=00/0", w, bd(w), observed(w));
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed8();
    single("add_carry", 8, 0, 'hF0, 'h20, 1'b0, pack('h10, 0, 4'b0100, 1'b0));
    single("sbc_borrow", 8, 3, 'h05, 'h05, 1'b1, pack('hFF, 0, 4'b0110, 1'b0));
    single("add_ovf", 8, 0, 'h7F, 'h01, 1'b0, pack('h80, 0, 4'b1010, 1'b0));
    single("sbc_allones", 8, 3, 'h10, 'hFF, 1'b1, pack('h10, 0, 4'b0100, 1'b0));
    multi("mul_ff_ff", 8, 14, 'hFF, 'hFF, 1'b0, pack('h01, 'hFE, 4'b0000, 1'b0), 3);
    multi("divu_200_7", 8, 15, 200, 7, 1'b0, pack(28, 4, 4'b0000, 1'b0), 0);
    multi("divu_by0", 8, 15, 'h55, 0, 1'b0, pack('hFF, 'h55, 4'b0010, 1'b1), 0);
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    single("pre_reset_add", 8, 0, 'h12, 'h34, 1'b0, pack('h46, 0, 4'b0000, 1'b0));
    @(negedge clk);
    drive(8, 1'b1, 14, 'hFF, 'hFF, 1'b0);
    @(posedge clk); #1;
    scramble(8);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bd(8) !== 2'b00 || observed(8) !== 37'd0) begin
      n_errors++;
      $display("FAIL mid_run_reset got=%b/%h exp=00/0", bd(8), observed(8));
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 24; k++) begin
      @(posedge clk); #1;
      if (done8 === 1'b1 || busy8 === 1'b1) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_errors++;
      $display("FAIL aborted_op_activity got=%0d exp=0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    longint ra, rb;
    logic [36:0] exp;
    @(negedge clk);
    drive(16, 1'b1, 13, 'h0001, rnd(16), 1'b1);
    @(posedge clk); #1;
    ra = rnd(16);
    rb = rnd(16);
    drive(16, 1'b1, 0, ra, rb, 1'b0);
    n_checks++;
    if (bd(16) !== 2'b01 || observed(16) !== pack('h8000, 0, 4'b0110, 1'b0)) begin
      n_errors++;
      $display("FAIL rrc16 got=%b/%h exp=01/%h", bd(16), observed(16),
               pack('h8000, 0, 4'b0110, 1'b0));
    end
    @(posedge clk); #1;
    scramble(16);
    exp = model(16, 0, ra, rb, 1'b0);
    n_checks++;
    if (bd(16) !== 2'b01 || observed(16) !== exp) begin
      n_errors++;
      $display("FAIL b2b_add16 got=%b/%h exp=01/%h", bd(16), observed(16), exp);
    end
    @(negedge clk);
    for (int i = 0; i < 24; i++) begin
      int op;
      longint a, b;
      logic cin;
      op = $urandom_range(0, 13);
      a = rnd(8);
      b = rnd(8);
      cin = 1'($urandom);
      drive(8, 1'b1, op, a, b, cin);
      @(posedge clk); #1;
      exp = model(8, op, a, b, cin);
      n_checks++;
      if (bd(8) !== 2'b01 || observed(8) !== exp) begin
        n_errors++;
        $display("FAIL stream8[%0d] op=%0d got=%b/%h exp=01/%h", i, op, bd(8), observed(8), exp);
      end
    end
    scramble(8);
    @(posedge clk); #1;
    n_checks++;
    if (bd(8) !== 2'b00) begin
      n_errors++;
      $display("FAIL stream8_end busy/done got=%b exp=00", bd(8));
    end
  endtask

  task automatic test_random(int w, int n);
    for (int i = 0; i < n; i++) begin
      int op;
      longint a, b;
      logic cin;
      op = $urandom_range(0, 15);
      a = rnd(w);
      b = rnd(w);
      cin = 1'($urandom);
      if (op >= 14) multi($sformatf("rand_w%0d_op%0d", w, op), w, op, a, b, cin,
                          model(w, op, a, b, cin), 0);
      else single($sformatf("rand_w%0d_op%0d", w, op), w, op, a, b, cin,
                  model(w, op, a, b, cin));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    drive(8, 1'b0, 0, 0, 0, 1'b0);
    drive(16, 1'b0, 0, 0, 0, 1'b0);
    test_reset();
    test_directed8();
    test_reset_mid_run();
    test_back_to_back();
    test_random(8, 120);
    test_random(16, 40);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
